// File: rtl/uart_rx_top.sv
// 8N1 UART receiver: synchronizes the serial line, centre-samples each bit and
// publishes the last correctly framed byte on uart_rxdata.
module uart_rx_top #(
    parameter int unsigned BD_RATE = 9600,
    parameter int unsigned RX_CLK  = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] uart_rxdata
);

    localparam int unsigned BIT_CNT = RX_CLK / BD_RATE;
    localparam int unsigned HALF    = BIT_CNT / 2;
    localparam int unsigned CNT_W   = $clog2(BIT_CNT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic             rx_meta;
    logic             rx_s;
    logic             rx_prev;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Frame FSM; every sample point is an offset from the detected start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            uart_rxdata <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (rx_prev && !rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_W'(BIT_CNT - 1)) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_W'(BIT_CNT - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                        // A low stop bit is a framing error: the byte is dropped.
                        if (rx_s) begin
                            uart_rxdata <= shift;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top at a scaled-down baud ratio (16 clk per bit).
module tb_uart_rx_top;

    localparam int unsigned BD_RATE = 62500;
    localparam int unsigned RX_CLK  = 1_000_000;
    localparam int unsigned BIT_CNT = RX_CLK / BD_RATE;
    localparam int unsigned HALF    = BIT_CNT / 2;

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic [7:0] uart_rxdata;

    int         n_cmp;
    int         n_bad;
    logic [7:0] model;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[8];

    uart_rx_top #(.BD_RATE(BD_RATE), .RX_CLK(RX_CLK)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .uart_rxdata(uart_rxdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        n_cmp++;
        if (uart_rxdata !== exp) begin
            n_bad++;
            $display("FAIL %s: uart_rxdata=%02h expected=%02h at %0t", name, uart_rxdata, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        uart_rx = b;
        tick(BIT_CNT);
    endtask

    // Idle gap (in bit times), start, 8 data bits LSB first, stop; checks hold and update.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int gap, input string name);
        for (int g = 0; g < gap; g++) send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        check({name, "_hold"}, model);
        uart_rx = stop;
        tick(HALF + 4);
        if (stop) model = data;
        check({name, "_stop"}, model);
        tick(BIT_CNT - HALF - 4);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        model   = 8'h00;
        uart_rx = 1'b1;
        rst     = 1'b0;

        tbl[0] = '{data: 8'h2A, stop: 1'b1, gap: 4, exp: 8'h2A};
        tbl[1] = '{data: 8'h55, stop: 1'b0, gap: 1, exp: 8'h2A};
        tbl[2] = '{data: 8'hA5, stop: 1'b1, gap: 2, exp: 8'hA5};
        tbl[3] = '{data: 8'h00, stop: 1'b1, gap: 0, exp: 8'h00};
        tbl[4] = '{data: 8'hFF, stop: 1'b1, gap: 0, exp: 8'hFF};
        tbl[5] = '{data: 8'h81, stop: 1'b0, gap: 0, exp: 8'hFF};
        tbl[6] = '{data: 8'h3C, stop: 1'b1, gap: 1, exp: 8'h3C};
        tbl[7] = '{data: 8'hC3, stop: 1'b1, gap: 0, exp: 8'hC3};

        tick(3);
        check("reset_active", 8'h00);
        rst = 1'b1;
        tick(200);
        check("reset_idle", 8'h00);

        // Table vectors: good frames, framing errors and back-to-back frames.
        foreach (tbl[i]) begin
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].gap, $sformatf("tbl%0d", i));
            n_cmp++;
            if (uart_rxdata !== tbl[i].exp) begin
                n_bad++;
                $display("FAIL tbl%0d_exp: uart_rxdata=%02h expected=%02h", i, uart_rxdata, tbl[i].exp);
            end
        end

        // Short low glitch must be rejected at the start-bit centre.
        uart_rx = 1'b0;
        tick(HALF / 2);
        uart_rx = 1'b1;
        tick(3 * BIT_CNT);
        check("glitch", model);

        // Framing error with the line held low: no new frame until it goes high.
        send_frame(8'h77, 1'b0, 1, "ferr_low");
        uart_rx = 1'b0;
        tick(3 * BIT_CNT);
        uart_rx = 1'b1;
        tick(2 * BIT_CNT);
        check("ferr_held_low", model);
        send_frame(8'h5A, 1'b1, 1, "after_ferr");

        // Randomized frames against the last-good-byte model.
        for (int r = 0; r < 20; r++) begin
            logic [7:0] d;
            logic       s;
            int         gp;
            d  = 8'($urandom);
            s  = ($urandom_range(0, 3) != 0);
            gp = $urandom_range(0, 2);
            if (r > 0 && gp == 0 && uart_rx == 1'b0) gp = 1;
            send_frame(d, s, gp, $sformatf("rnd%0d", r));
        end

        // Reset asserted during data bit 4 of 0x3C, held to the end of that frame.
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(tbl[6].data[i]);
        uart_rx = tbl[6].data[4];
        tick(HALF);
        rst = 1'b0;
        model = 8'h00;
        tick(2);
        check("rst_mid_frame", 8'h00);
        tick(BIT_CNT - HALF - 2);
        for (int i = 5; i < 8; i++) send_bit(tbl[6].data[i]);
        send_bit(1'b1);
        rst = 1'b1;
        tick(2 * BIT_CNT);
        check("rst_released", 8'h00);
        send_frame(8'h3C, 1'b1, 1, "after_rst");
        tick(4 * BIT_CNT);
        check("final_hold", 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
